// File: rtl/fifo_wr_ingress.sv
// Write-domain ingress of the async FIFO: skid-buffered valid/ready intake,
// read-pointer synchronizer, space-guarded write issue and flush sequencing.
module fifo_wr_ingress #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned PTR_WIDTH    = 4,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned AFULL_THRESH = 12
) (
    input  logic                  w_clk,
    input  logic                  wresetn,
    input  logic                  flush,
    input  logic                  s_tvalid,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    output logic                  s_tready,
    input  logic [PTR_WIDTH:0]    rptr_gray,
    output logic                  wr_enable,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  flush_o,
    output logic [PTR_WIDTH:0]    read_ptr,
    output logic [PTR_WIDTH:0]    wr_level,
    output logic                  almost_full
);

    localparam int unsigned PW    = PTR_WIDTH + 1;
    localparam int unsigned DEPTH = 1 << PTR_WIDTH;
    localparam int unsigned CNT_W = $clog2(SYNC_STAGES + 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_RESYNC = 2'd2
    } state_e;

    state_e                state_q;
    state_e                state_d;
    logic [CNT_W-1:0]      rcnt_q;
    logic [CNT_W-1:0]      rcnt_d;

    logic [PW-1:0]         sync_q [SYNC_STAGES];
    logic [PW-1:0]         read_ptr_q;
    logic [PW-1:0]         wptr_q;
    logic [PW-1:0]         wptr_d;

    logic                  ov_q;
    logic                  ov_d;
    logic [DATA_WIDTH-1:0] od_q;
    logic [DATA_WIDTH-1:0] od_d;
    logic                  sv_q;
    logic                  sv_d;
    logic [DATA_WIDTH-1:0] sd_q;
    logic [DATA_WIDTH-1:0] sd_d;

    logic                  run_c;
    logic                  space_c;
    logic                  consume_c;
    logic                  accept_c;
    logic [PW-1:0]         level_c;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b = g;
        for (int i = 1; i < int'(PW); i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

    // Occupancy seen from the write side; lags reads, so never overstates space.
    assign level_c   = wptr_q - read_ptr_q;
    assign space_c   = (level_c < PW'(DEPTH));
    assign run_c     = (state_q == ST_RUN) && !flush;
    assign consume_c = ov_q && space_c && run_c;
    assign accept_c  = s_tvalid && s_tready;

    // FSM state register
    always_ff @(posedge w_clk or negedge wresetn) begin
        if (!wresetn) begin
            state_q <= ST_RUN;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
        end
    end

    // FSM next state; a flush request restarts the sequence from any state
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        if (flush) begin
            state_d = ST_FLUSH;
            rcnt_d  = '0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    state_d = ST_RUN;
                end
                ST_FLUSH: begin
                    state_d = ST_RESYNC;
                    rcnt_d  = '0;
                end
                ST_RESYNC: begin
                    if (rcnt_q == CNT_W'(SYNC_STAGES)) begin
                        state_d = ST_RUN;
                        rcnt_d  = '0;
                    end else begin
                        rcnt_d = rcnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    rcnt_d  = '0;
                end
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        s_tready  = 1'b0;
        wr_enable = 1'b0;
        flush_o   = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                s_tready  = !sv_q && !flush;
                wr_enable = consume_c;
            end
            ST_FLUSH: begin
                wr_enable = 1'b1;
                flush_o   = 1'b1;
            end
            ST_RESYNC: begin
                s_tready  = 1'b0;
                wr_enable = 1'b0;
            end
            default: begin
                s_tready  = 1'b0;
                wr_enable = 1'b0;
            end
        endcase
    end

    // Skid buffer and local write pointer next state
    always_comb begin
        ov_d   = ov_q;
        od_d   = od_q;
        sv_d   = sv_q;
        sd_d   = sd_q;
        wptr_d = wptr_q;
        if (consume_c) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (sv_q) begin
            if (consume_c) begin
                ov_d = 1'b1;
                od_d = sd_q;
                sv_d = 1'b0;
            end
        end else if (consume_c || !ov_q) begin
            ov_d = accept_c;
            if (accept_c) begin
                od_d = s_tdata;
            end
        end else if (accept_c) begin
            sv_d = 1'b1;
            sd_d = s_tdata;
        end
    end

    // Datapath registers; a sampled flush wipes buffered beats and pointers
    always_ff @(posedge w_clk or negedge wresetn) begin
        if (!wresetn) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
            read_ptr_q <= '0;
            wptr_q     <= '0;
            ov_q       <= 1'b0;
            od_q       <= '0;
            sv_q       <= 1'b0;
            sd_q       <= '0;
        end else if (flush) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
            read_ptr_q <= '0;
            wptr_q     <= '0;
            ov_q       <= 1'b0;
            od_q       <= '0;
            sv_q       <= 1'b0;
            sd_q       <= '0;
        end else begin
            sync_q[0] <= rptr_gray;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            read_ptr_q <= gray2bin(sync_q[SYNC_STAGES-1]);
            wptr_q     <= wptr_d;
            ov_q       <= ov_d;
            od_q       <= od_d;
            sv_q       <= sv_d;
            sd_q       <= sd_d;
        end
    end

    assign wr_data     = od_q;
    assign read_ptr    = read_ptr_q;
    assign wr_level    = level_c;
    assign almost_full = (level_c >= PW'(AFULL_THRESH));

endmodule

// File: tb/tb_fifo_wr_ingress.sv
// Directed bench for fifo_wr_ingress: streaming, fill/drain, random backpressure,
// pointer wrap, flush sequencing and asynchronous reset.
module tb_fifo_wr_ingress;

    logic       w_clk;
    logic       wresetn;
    logic       flush;
    logic       s_tvalid;
    logic [7:0] s_tdata;
    logic       s_tready;
    logic [4:0] rptr_gray;
    logic       wr_enable;
    logic [7:0] wr_data;
    logic       flush_o;
    logic [4:0] read_ptr;
    logic [4:0] wr_level;
    logic       almost_full;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    int wr_cnt = 0;
    int rcnt = 0;
    logic [7:0] exp_q[$];

    fifo_wr_ingress #(
        .DATA_WIDTH  (8),
        .PTR_WIDTH   (4),
        .SYNC_STAGES (2),
        .AFULL_THRESH(12)
    ) dut (
        .w_clk      (w_clk),
        .wresetn    (wresetn),
        .flush      (flush),
        .s_tvalid   (s_tvalid),
        .s_tdata    (s_tdata),
        .s_tready   (s_tready),
        .rptr_gray  (rptr_gray),
        .wr_enable  (wr_enable),
        .wr_data    (wr_data),
        .flush_o    (flush_o),
        .read_ptr   (read_ptr),
        .wr_level   (wr_level),
        .almost_full(almost_full)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] gray5(input int b);
        logic [4:0] v;
        v = 5'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic settle();
        #2;
    endtask

    // Score this cycle's handshakes, then move to the next cycle start.
    task automatic adv();
        if (wr_enable && !flush_o) begin
            wr_cnt++;
            chk("write_has_beat", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("wr_data_order", 32'(wr_data), 32'(exp_q.pop_front()));
        end
        if (s_tvalid && s_tready) begin
            exp_q.push_back(s_tdata);
            acc_cnt++;
        end
        @(posedge w_clk);
        #1;
    endtask

    task automatic step();
        settle();
        adv();
    endtask

    task automatic run(input int n_total, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            s_tvalid = (acc_cnt < n_total);
            s_tdata  = 8'(acc_cnt + 1);
            step();
        end
        s_tvalid = 1'b0;
    endtask

    task automatic do_reset();
        wresetn   = 1'b0;
        flush     = 1'b0;
        s_tvalid  = 1'b0;
        rptr_gray = '0;
        exp_q.delete();
        acc_cnt = 0;
        wr_cnt  = 0;
        rcnt    = 0;
        #2;
        wresetn = 1'b1;
        @(posedge w_clk);
        #1;
    endtask

    initial begin
        wresetn   = 1'b0;
        flush     = 1'b0;
        s_tvalid  = 1'b0;
        s_tdata   = '0;
        rptr_gray = '0;
        #3;
        chk("rst_read_ptr", 32'(read_ptr), 32'd0);
        chk("rst_wr_level", 32'(wr_level), 32'd0);
        chk("rst_afull", 32'(almost_full), 32'd0);
        chk("rst_wr_en", 32'(wr_enable), 32'd0);
        chk("rst_flush_o", 32'(flush_o), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_tready", 32'(s_tready), 32'd1);
        @(posedge w_clk);
        #1;
        wresetn = 1'b1;
        @(posedge w_clk);
        #1;

        // Stream 8 beats back to back
        for (int k = 0; k < 10; k++) begin
            s_tvalid = (k < 8);
            s_tdata  = 8'(k + 1);
            settle();
            chk("t1_tready", 32'(s_tready), 32'd1);
            chk("t1_wr_en", 32'(wr_enable), 32'(k >= 1 && k <= 8));
            if (k >= 1 && k <= 8) chk("t1_wr_data", 32'(wr_data), 32'(k));
            adv();
        end
        s_tvalid = 1'b0;
        settle();
        chk("t1_level", 32'(wr_level), 32'd8);
        chk("t1_afull", 32'(almost_full), 32'd0);
        adv();

        // Fill with read pointer held at 0
        do_reset();
        for (int c = 0; c < 30; c++) begin
            s_tvalid = (acc_cnt < 20);
            s_tdata  = 8'(acc_cnt + 1);
            settle();
            chk("t2_afull", 32'(almost_full), 32'(wr_cnt >= 12));
            adv();
        end
        settle();
        chk("t2_writes", 32'(wr_cnt), 32'd16);
        chk("t2_accepts", 32'(acc_cnt), 32'd18);
        chk("t2_tready", 32'(s_tready), 32'd0);
        chk("t2_wr_en", 32'(wr_enable), 32'd0);
        chk("t2_level", 32'(wr_level), 32'd16);
        chk("t2_held", 32'(exp_q.size()), 32'd2);

        // Drain release: read pointer to 4 (Gray 0x06)
        rptr_gray = 5'h06;
        for (int d = 0; d < 8; d++) begin
            s_tvalid = (acc_cnt < 20);
            s_tdata  = 8'(acc_cnt + 1);
            settle();
            chk("t3_wr_en", 32'(wr_enable), 32'(d >= 3 && d <= 6));
            if (d >= 3 && d <= 6) chk("t3_wr_data", 32'(wr_data), 32'(d + 14));
            adv();
        end
        s_tvalid = 1'b0;
        settle();
        chk("t3_writes", 32'(wr_cnt), 32'd20);
        chk("t3_read_ptr", 32'(read_ptr), 32'd4);
        chk("t3_level", 32'(wr_level), 32'd16);
        adv();

        // Random producer and advancing reader over 1000 beats
        do_reset();
        begin
            bit done;
            done = 1'b0;
            for (int c = 0; c < 20000 && !done; c++) begin
                s_tvalid = (acc_cnt < 1000) && ($urandom_range(0, 99) < 60);
                s_tdata  = 8'($urandom);
                if (rcnt < wr_cnt && $urandom_range(0, 1) == 1) rcnt++;
                rptr_gray = gray5(rcnt);
                step();
                done = (wr_cnt == 1000) && (rcnt == 1000);
            end
            chk("t4_budget", 32'(done), 32'd1);
        end
        s_tvalid = 1'b0;
        for (int c = 0; c < 4; c++) step();
        settle();
        chk("t4_writes", 32'(wr_cnt), 32'd1000);
        chk("t4_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("t4_read_ptr", 32'(read_ptr), 32'd8);
        chk("t4_level", 32'(wr_level), 32'd0);
        adv();

        // Pointer wrap: wptr 8 -> 24 -> 0 while read_ptr goes 8 -> 24 -> 28
        run(acc_cnt + 16, 20);
        settle();
        chk("wrap_full", 32'(wr_level), 32'd16);
        adv();
        rptr_gray = 5'h14;
        for (int c = 0; c < 4; c++) step();
        settle();
        chk("wrap_rp24", 32'(read_ptr), 32'd24);
        chk("wrap_lvl0", 32'(wr_level), 32'd0);
        adv();
        run(acc_cnt + 8, 12);
        settle();
        chk("wrap_lvl8", 32'(wr_level), 32'd8);
        adv();
        rptr_gray = 5'h12;
        for (int c = 0; c < 4; c++) step();
        settle();
        chk("wrap_rp28", 32'(read_ptr), 32'd28);
        chk("wrap_lvl4", 32'(wr_level), 32'd4);
        chk("wrap_afull", 32'(almost_full), 32'd0);
        adv();

        // Flush with two beats buffered
        run(acc_cnt + 14, 20);
        settle();
        chk("t5_pre_tready", 32'(s_tready), 32'd0);
        chk("t5_pre_level", 32'(wr_level), 32'd16);
        chk("t5_pre_held", 32'(exp_q.size()), 32'd2);
        adv();
        flush     = 1'b1;
        s_tvalid  = 1'b1;
        s_tdata   = 8'hEE;
        rptr_gray = '0;
        settle();
        chk("t5_f0_tready", 32'(s_tready), 32'd0);
        chk("t5_f0_wr_en", 32'(wr_enable), 32'd0);
        chk("t5_f0_flush_o", 32'(flush_o), 32'd0);
        adv();
        exp_q.delete();
        flush    = 1'b0;
        s_tvalid = 1'b0;
        settle();
        chk("t5_f1_wr_en", 32'(wr_enable), 32'd1);
        chk("t5_f1_flush_o", 32'(flush_o), 32'd1);
        chk("t5_f1_tready", 32'(s_tready), 32'd0);
        chk("t5_f1_level", 32'(wr_level), 32'd0);
        chk("t5_f1_read_ptr", 32'(read_ptr), 32'd0);
        adv();
        for (int c = 0; c < 3; c++) begin
            s_tvalid = 1'b1;
            settle();
            chk("t5_resync_tready", 32'(s_tready), 32'd0);
            chk("t5_resync_wr_en", 32'(wr_enable), 32'd0);
            chk("t5_resync_flush_o", 32'(flush_o), 32'd0);
            adv();
        end
        s_tvalid = 1'b0;
        settle();
        chk("t5_run_tready", 32'(s_tready), 32'd1);
        chk("t5_run_level", 32'(wr_level), 32'd0);
        adv();
        run(acc_cnt + 2, 4);
        settle();
        chk("t5_post_level", 32'(wr_level), 32'd2);
        chk("t5_post_sb", 32'(exp_q.size()), 32'd0);
        adv();

        // Flush colliding with a pending consume
        s_tvalid = 1'b1;
        s_tdata  = 8'h55;
        settle();
        chk("g0_tready", 32'(s_tready), 32'd1);
        adv();
        s_tvalid = 1'b0;
        flush    = 1'b1;
        settle();
        chk("g1_wr_en", 32'(wr_enable), 32'd0);
        chk("g1_tready", 32'(s_tready), 32'd0);
        adv();
        exp_q.delete();
        flush = 1'b0;
        settle();
        chk("g2_wr_en", 32'(wr_enable), 32'd1);
        chk("g2_flush_o", 32'(flush_o), 32'd1);
        adv();
        for (int c = 0; c < 4; c++) step();
        settle();
        chk("g_level", 32'(wr_level), 32'd0);
        chk("g_tready", 32'(s_tready), 32'd1);
        adv();

        // Asynchronous reset in the middle of a burst
        run(acc_cnt + 10, 5);
        s_tvalid = 1'b1;
        s_tdata  = 8'(acc_cnt + 1);
        settle();
        chk("t6_pre_wr_en", 32'(wr_enable), 32'd1);
        wresetn = 1'b0;
        #1;
        chk("t6_wr_en", 32'(wr_enable), 32'd0);
        chk("t6_flush_o", 32'(flush_o), 32'd0);
        chk("t6_wr_data", 32'(wr_data), 32'd0);
        chk("t6_level", 32'(wr_level), 32'd0);
        chk("t6_read_ptr", 32'(read_ptr), 32'd0);
        chk("t6_afull", 32'(almost_full), 32'd0);
        chk("t6_tready", 32'(s_tready), 32'd1);
        s_tvalid = 1'b0;
        exp_q.delete();
        acc_cnt = 0;
        wr_cnt  = 0;
        #1;
        wresetn = 1'b1;
        @(posedge w_clk);
        #1;
        run(3, 6);
        settle();
        chk("t6_post_level", 32'(wr_level), 32'd3);
        adv();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
